display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one display7seg decoder. It holds the value written by the processor, presents one nibble per refresh slot on the decoder inputs (dado, dp), and drives the active-low anode selects. Writes use a valid/ready handshake and are applied only at a frame boundary, so a frame never mixes old and new digits. It also provides leading-zero blanking and a forced-dash mode.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 50000, clock cycles per digit slot (>=2)

Ports:
clock  in  1  system clock, single clock domain
reset  in  1  synchronous, active-high reset
wr_en  in  1  write valid
wr_data  in  4*NUM_DIGITS  value to display; nibble i maps to digit i (0 = rightmost)
wr_ready  out  1  write ready
blank_lz  in  1  enable leading-zero blanking
dash_en  in  1  force dash on all digits
dado  out  4  nibble to the decoder's dado input
dp  out  1  to the decoder's dp input (1 = digit, 0 = dash)
an  out  NUM_DIGITS  anode selects, active-low
frame_tick  out  1  one-cycle pulse when a new frame starts

Behaviour:
- All outputs are registered.
- Reset values: an = all ones, dado = 0, dp = 1, wr_ready = 1, frame_tick = 0.
- Reset also clears shown = 0, pending = 0, div counter = 0 and slot index idx = NUM_DIGITS-1.
- Divider: the counter runs 0..REFRESH_DIV-1 and wraps to 0. The edge where counter == REFRESH_DIV-1 is the slot edge.
- Slot edge: idx <= idx+1, wrapping NUM_DIGITS-1 -> 0. On the same edge, dado/dp/an are loaded for the new idx, so the outputs hold for exactly REFRESH_DIV cycles. The first lit slot after reset is digit 0, REFRESH_DIV cycles after reset deasserts.
- Frame edge: a slot edge where idx == NUM_DIGITS-1 (wrap to 0).
  - frame_tick is high the cycle after a frame edge.
  - If pending = 1: shown <= pending_data, pending <= 0.
  - Digit 0 of the new frame already uses the transferred data.
- Write handshake:
  - wr_ready = ~pending.
  - wr_en & wr_ready: capture pending_data <= wr_data, pending <= 1; wr_ready goes low the next cycle.
  - wr_en while wr_ready = 0: ignored, no effect, no queuing.
  - wr_ready returns high the cycle after the transfer edge.
  - wr_en on the same cycle as a transfer edge is ignored, because wr_ready is still low.
- Slot output for digit i (source = shown, or the transferred value on a frame edge):
  - dado = nibble i.
  - dash_en = 1: dp = 0 and an[i] = 0 (lit dash); this overrides blanking.
  - else blank_lz = 1, i != 0, and nibbles i..NUM_DIGITS-1 all zero: an = all ones (digit dark), dp = 1.
  - else dp = 1, an = ~(1 << i).
  - Digit 0 is never blanked.
- blank_lz and dash_en are sampled only at slot edges. Changes take effect at the next slot, never mid-slot.
- Exactly one anode or none is low at any time.
- Reset mid-operation: any pending write is discarded and shown = 0. Scanning restarts as from power-up.
- Counter width = ceil(log2(REFRESH_DIV)). Index width = ceil(log2(NUM_DIGITS)), min 1. No other arithmetic.

Test Plan (REFRESH_DIV=4, NUM_DIGITS=4):
1. Reset for 2 cycles, then release.
   - Required: an=1111, dp=1, dado=0, wr_ready=1 for 4 cycles.
   - Then an=1110, dado=0.
   - frame_tick pulses one cycle after that edge.
2. Write 0x1A3F with wr_ready=1.
   - wr_ready=0 next cycle; the rest of the current frame still shows 0.
   - The next frame shows slot0 dado=F an=1110, slot1 3/1101, slot2 A/1011, slot3 1/0111.
   - wr_ready=1 the cycle after the transfer edge.
3. blank_lz=1, value 0x0030.
   - Slots 3 and 2: an=1111. Slot1: dado=3 an=1101. Slot0: dado=0 an=1110.
   - Value 0x0000: only slot 0 is lit.
4. dash_en=1 with blank_lz=1 and value 0x0000.
   - Every slot has dp=0 and an cycles 1110, 1101, 1011, 0111.
5. Hold wr_en=1: write 0x1111, then 0x2222 on the following cycles.
   - 0x2222 is ignored while pending; the frame shows 1111.
   - After wr_ready rises, the still-asserted wr_en captures 0x2222, which is shown from the following frame.
6. Write 0x9999, then assert reset before the frame edge.
   - After reset: wr_ready=1, all digits show 0, and 9999 never appears.

Source files
------------

// File: rtl/display_scan_ctrl_if.sv
// Processor write port and decoder/anode side of the 7-segment scan controller.
interface display_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      wr_en;
    logic [4*NUM_DIGITS-1:0]   wr_data;
    logic                      wr_ready;
    logic                      blank_lz;
    logic                      dash_en;
    logic [3:0]                dado;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_tick;

    modport master (
        output wr_en, wr_data, blank_lz, dash_en,
        input  wr_ready, dado, dp, an, frame_tick
    );

    modport slave (
        input  wr_en, wr_data, blank_lz, dash_en,
        output wr_ready, dado, dp, an, frame_tick
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner; writes are staged and swapped in
// only at frame boundaries so a frame never mixes old and new digits.
module display_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                 clock,
    input  logic                 reset,
    display_scan_ctrl_if.slave   bus
);
    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS  > 2) ? $clog2(NUM_DIGITS)  : 1;
    localparam int DW    = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      r_div;
    logic [IDX_W-1:0]      r_idx;
    logic [DW-1:0]         r_shown;
    logic [DW-1:0]         r_pdata;
    logic                  r_pend;
    logic                  r_rdy;
    logic [3:0]            r_dado;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_ft;

    logic                  w_slot;
    logic                  w_frame;
    logic                  w_xfer;
    logic                  w_accept;
    logic [DW-1:0]         w_src;
    logic [IDX_W-1:0]      w_idx_nx;
    logic [NUM_DIGITS-1:0] w_lz;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [3:0]            w_nib;
    logic                  w_hit_lz;
    logic                  w_blank;

    assign w_slot   = (r_div == DIV_LAST);
    assign w_frame  = w_slot && (r_idx == IDX_LAST);
    assign w_xfer   = w_frame && r_pend;
    assign w_accept = bus.wr_en && r_rdy;
    // On the transfer edge digit 0 must already show the new value.
    assign w_src    = w_xfer ? r_pdata : r_shown;
    assign w_idx_nx = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

    // w_lz[i]: nibbles i..NUM_DIGITS-1 are all zero.
    always_comb begin
        w_lz = '0;
        w_lz[NUM_DIGITS-1] = (w_src[DW-1 -: 4] == 4'd0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            w_lz[k] = w_lz[k+1] && (w_src[4*k +: 4] == 4'd0);
        end
    end

    always_comb begin
        w_nib    = '0;
        w_hit_lz = 1'b0;
        w_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IDX_W'(k) == w_idx_nx) begin
                w_nib       = w_src[4*k +: 4];
                w_hit_lz    = w_lz[k];
                w_onehot[k] = 1'b1;
            end
        end
    end

    assign w_blank = bus.blank_lz && (w_idx_nx != '0) && w_hit_lz;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div   <= '0;
            r_idx   <= IDX_LAST;
            r_shown <= '0;
            r_pdata <= '0;
            r_pend  <= 1'b0;
            r_rdy   <= 1'b1;
            r_dado  <= '0;
            r_dp    <= 1'b1;
            r_an    <= '1;
            r_ft    <= 1'b0;
        end else begin
            r_div <= w_slot ? '0 : r_div + 1'b1;
            r_ft  <= w_frame;
            // Accept and transfer are exclusive: accept needs pending clear.
            if (w_xfer) begin
                r_shown <= r_pdata;
                r_pend  <= 1'b0;
                r_rdy   <= 1'b1;
            end else if (w_accept) begin
                r_pdata <= bus.wr_data;
                r_pend  <= 1'b1;
                r_rdy   <= 1'b0;
            end
            if (w_slot) begin
                r_idx  <= w_idx_nx;
                r_dado <= w_nib;
                if (bus.dash_en) begin
                    r_dp <= 1'b0;
                    r_an <= ~w_onehot;
                end else if (w_blank) begin
                    r_dp <= 1'b1;
                    r_an <= '1;
                end else begin
                    r_dp <= 1'b1;
                    r_an <= ~w_onehot;
                end
            end
        end
    end

    assign bus.wr_ready   = r_rdy;
    assign bus.dado       = r_dado;
    assign bus.dp         = r_dp;
    assign bus.an         = r_an;
    assign bus.frame_tick = r_ft;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a cycle model queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_display_scan_ctrl;
    localparam int ND = 4;
    localparam int RD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_scan_ctrl_if #(.NUM_DIGITS(ND)) bus();

    display_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [ND-1:0] an;
        logic [3:0]    dado;
        logic          dp;
        logic          rdy;
        logic          ft;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errs    = 0;
    int   nines   = 0;
    bit   phase6  = 1'b0;

    // model state
    int             m_div, m_idx;
    logic [4*ND-1:0] m_shown, m_pdata;
    bit             m_pend;
    exp_t           m_out;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the reference behaviour, using the inputs about to be sampled.
    task automatic model_step();
        bit slot, fedge, accept;
        logic [4*ND-1:0] src, upper;
        if (rst) begin
            m_div = 0; m_idx = ND - 1;
            m_shown = '0; m_pdata = '0; m_pend = 0;
            m_out.an = '1; m_out.dado = '0; m_out.dp = 1'b1;
            m_out.rdy = 1'b1; m_out.ft = 1'b0;
            return;
        end
        slot   = (m_div == RD - 1);
        m_div  = slot ? 0 : m_div + 1;
        fedge  = slot && (m_idx == ND - 1);
        src    = (fedge && m_pend) ? m_pdata : m_shown;
        accept = bus.wr_en && !m_pend;
        m_out.ft = fedge;
        if (fedge && m_pend) begin
            m_shown = m_pdata;
            m_pend  = 0;
        end else if (accept) begin
            m_pdata = bus.wr_data;
            m_pend  = 1;
        end
        m_out.rdy = !m_pend;
        if (slot) begin
            m_idx = (m_idx + 1) % ND;
            upper = src >> (4 * m_idx);
            m_out.dado = upper[3:0];
            if (bus.dash_en) begin
                m_out.dp = 1'b0;
                m_out.an = ~(ND'(1) << m_idx);
            end else if (bus.blank_lz && m_idx != 0 && upper == '0) begin
                m_out.dp = 1'b1;
                m_out.an = '1;
            end else begin
                m_out.dp = 1'b1;
                m_out.an = ~(ND'(1) << m_idx);
            end
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("an",         32'(bus.an),         32'(e.an));
                chk("dado",       32'(bus.dado),       32'(e.dado));
                chk("dp",         32'(bus.dp),         32'(e.dp));
                chk("wr_ready",   32'(bus.wr_ready),   32'(e.rdy));
                chk("frame_tick", 32'(bus.frame_tick), 32'(e.ft));
                chk("an_onehot",  32'($countones(~bus.an) <= 1), 32'd1);
                if (phase6 && bus.dado == 4'h9) nines++;
            end
            model_step();
            sb.push_back(m_out);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [4*ND-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick(1);
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        int budget;
        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        bus.blank_lz = 1'b0;
        bus.dash_en  = 1'b0;

        // 1: reset, first lit slot is digit 0 after RD cycles
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("pre_slot_an", 32'(bus.an), 32'hF);
        tick(1);
        chk("first_slot_an", 32'(bus.an), 32'hE);
        tick(7);

        // 2: staged write shown from the next frame
        write(16'h1A3F);
        chk("busy_after_wr", 32'(bus.wr_ready), 32'd0);
        tick(32);

        // 3: leading-zero blanking
        bus.blank_lz = 1'b1;
        write(16'h0030);
        tick(32);
        write(16'h0000);
        tick(32);

        // 4: dash overrides blanking
        bus.dash_en = 1'b1;
        tick(20);
        bus.dash_en  = 1'b0;
        bus.blank_lz = 1'b0;
        tick(3);

        // 5: held wr_en, second value ignored until ready returns
        bus.wr_en   = 1'b1;
        bus.wr_data = 16'h1111;
        tick(1);
        bus.wr_data = 16'h2222;
        tick(40);
        bus.wr_en = 1'b0;
        tick(32);

        // 6: reset discards a pending write
        budget = 0;
        while (bus.frame_tick !== 1'b1 && budget < 40) begin
            tick(1);
            budget++;
        end
        chk("ft_wait", 32'(budget < 40), 32'd1);
        phase6 = 1'b1;
        write(16'h9999);
        tick(3);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(40);
        chk("no_9999", 32'(nines), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
